// File: rtl/hex_display_bank.sv
// Multi-digit hex seven-segment driver: latched value with load/ack, registered segments,
// per-digit blink, leading-zero blanking, selectable polarity. Optional lamp test: HEX_DISPLAY_LAMP_TEST_EN.
module hex_display_bank #(
   parameter int NUM_DIGITS = 4,
   parameter bit ACTIVE_LOW = 1'b1,
   parameter int BLINK_DIV  = 25000000
`ifdef HEX_DISPLAY_LAMP_TEST_EN
   ,
   parameter int LAMP_CYCLES = 50000000
`endif
) (
   input  logic                    clk,
   input  logic                    resetN,
   input  logic                    load,
   input  logic [4*NUM_DIGITS-1:0] value,
   output logic                    load_ack,
   input  logic                    blank_lz,
   input  logic [NUM_DIGITS-1:0]   blink_mask,
`ifdef HEX_DISPLAY_LAMP_TEST_EN
   input  logic                    lamp_test,
`endif
   output logic                    blink_phase,
   output logic [7*NUM_DIGITS-1:0] seg_out
);

   localparam int CNT_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(BLINK_DIV - 1);
   localparam logic [6:0] SEG_OFF = ACTIVE_LOW ? 7'h7F : 7'h00;
   localparam logic [6:0] SEG_ON  = ~SEG_OFF;

   // Patterns are stored in active-low form and inverted for active-high boards.
   function automatic logic [6:0] f_decode(input logic [3:0] d);
      logic [6:0] p;
      case (d)
         4'h0: p = 7'h40;
         4'h1: p = 7'h79;
         4'h2: p = 7'h24;
         4'h3: p = 7'h30;
         4'h4: p = 7'h19;
         4'h5: p = 7'h12;
         4'h6: p = 7'h02;
         4'h7: p = 7'h78;
         4'h8: p = 7'h00;
         4'h9: p = 7'h18;
         4'hA: p = 7'h08;
         4'hB: p = 7'h03;
         4'hC: p = 7'h46;
         4'hD: p = 7'h21;
         4'hE: p = 7'h06;
         default: p = 7'h0E;
      endcase
      return ACTIVE_LOW ? p : ~p;
   endfunction

   logic [4*NUM_DIGITS-1:0] r_value;
   logic                    r_load_ack;
   logic [CNT_W-1:0]        r_blink_cnt;
   logic                    r_blink_phase;
   logic [7*NUM_DIGITS-1:0] r_seg;
   logic [7*NUM_DIGITS-1:0] w_seg_next;
   logic                    w_zero_run;
   logic                    w_lamp_on;

   // Stage 0: value latch and handshake
   always_ff @(posedge clk) begin
      if (!resetN) begin
         r_value    <= '0;
         r_load_ack <= 1'b0;
      end else begin
         r_load_ack <= load;
         if (load)
            r_value <= value;
      end
   end

   always_ff @(posedge clk) begin
      if (!resetN) begin
         r_blink_cnt   <= '0;
         r_blink_phase <= 1'b0;
      end else if (r_blink_cnt == CNT_MAX) begin
         r_blink_cnt   <= '0;
         r_blink_phase <= ~r_blink_phase;
      end else begin
         r_blink_cnt <= r_blink_cnt + 1'b1;
      end
   end

`ifdef HEX_DISPLAY_LAMP_TEST_EN
   localparam int LC_W = (LAMP_CYCLES > 1) ? $clog2(LAMP_CYCLES) : 1;
   localparam logic [LC_W-1:0] LAMP_MAX = LC_W'(LAMP_CYCLES - 1);

   typedef enum logic {S_IDLE, S_TEST} lamp_state_t;
   lamp_state_t     r_state;
   logic [LC_W-1:0] r_lamp_cnt;

   always_ff @(posedge clk) begin
      if (!resetN) begin
         r_state    <= S_IDLE;
         r_lamp_cnt <= '0;
      end else if (lamp_test) begin
         r_state    <= S_TEST;
         r_lamp_cnt <= LAMP_MAX;
      end else if (r_state == S_TEST) begin
         if (r_lamp_cnt == '0)
            r_state <= S_IDLE;
         else
            r_lamp_cnt <= r_lamp_cnt - 1'b1;
      end
   end

   // Lit from the pulse edge through the edge that decrements to zero: LAMP_CYCLES cycles.
   assign w_lamp_on = lamp_test || (r_state == S_TEST && r_lamp_cnt != '0);
`else
   assign w_lamp_on = 1'b0;
`endif

   // Zero-run flag walks from the most significant digit and stops at the first nonzero one.
   always_comb begin
      w_zero_run = blank_lz;
      w_seg_next = '0;
      for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
         w_zero_run = w_zero_run && (r_value[4*i +: 4] == 4'h0);
         if (w_lamp_on)
            w_seg_next[7*i +: 7] = SEG_ON;
         else if ((w_zero_run && i != 0) || (r_blink_phase && blink_mask[i]))
            w_seg_next[7*i +: 7] = SEG_OFF;
         else
            w_seg_next[7*i +: 7] = f_decode(r_value[4*i +: 4]);
      end
   end

   // Stage 1: registered segment outputs
   always_ff @(posedge clk) begin
      if (!resetN)
         r_seg <= {NUM_DIGITS{SEG_OFF}};
      else
         r_seg <= w_seg_next;
   end

   assign load_ack    = r_load_ack;
   assign blink_phase = r_blink_phase;
   assign seg_out     = r_seg;

endmodule

// File: tb/tb_hex_display_bank.sv
// Self-checking bench for hex_display_bank: 4 digits, active-low, BLINK_DIV = 4.
// Exercises the lamp test as well when HEX_DISPLAY_LAMP_TEST_EN is defined.
module tb_hex_display_bank;

   logic        clk = 1'b0;
   logic        resetN = 1'b0;
   logic        load = 1'b0;
   logic [15:0] value = '0;
   logic        load_ack;
   logic        blank_lz = 1'b0;
   logic [3:0]  blink_mask = '0;
   logic        blink_phase;
   logic [27:0] seg_out;
`ifdef HEX_DISPLAY_LAMP_TEST_EN
   logic        lamp_test = 1'b0;
`endif

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [15:0] value;
      logic        blz;
      logic [27:0] exp;
   } vec_t;

   typedef struct {
      int          idx;
      logic [27:0] exp;
   } sb_t;

   vec_t vec[9];
   sb_t  sbq[$];

   hex_display_bank #(
      .NUM_DIGITS (4),
      .ACTIVE_LOW (1'b1),
      .BLINK_DIV  (4)
`ifdef HEX_DISPLAY_LAMP_TEST_EN
      ,
      .LAMP_CYCLES(5)
`endif
   ) dut (
      .clk        (clk),
      .resetN     (resetN),
      .load       (load),
      .value      (value),
      .load_ack   (load_ack),
      .blank_lz   (blank_lz),
      .blink_mask (blink_mask),
`ifdef HEX_DISPLAY_LAMP_TEST_EN
      .lamp_test  (lamp_test),
`endif
      .blink_phase(blink_phase),
      .seg_out    (seg_out)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog expired before the test completed");
      $fatal(1);
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string nm, input logic [27:0] act, input logic [27:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", nm, act, exp);
      end
   endtask

   initial begin
      sb_t e;
      logic prev_phase;
      int   run;
      int   toggles;
      bit   seen;
      bit   found;
      int   lit_cnt;

      vec[0] = '{16'h12AF, 1'b0, {7'h79, 7'h24, 7'h08, 7'h0E}};
      vec[1] = '{16'h00A0, 1'b1, {7'h7F, 7'h7F, 7'h08, 7'h40}};
      vec[2] = '{16'h0000, 1'b1, {7'h7F, 7'h7F, 7'h7F, 7'h40}};
      vec[3] = '{16'h1000, 1'b1, {7'h79, 7'h40, 7'h40, 7'h40}};
      vec[4] = '{16'h0000, 1'b0, {7'h40, 7'h40, 7'h40, 7'h40}};
      vec[5] = '{16'h0305, 1'b1, {7'h7F, 7'h30, 7'h40, 7'h12}};
      vec[6] = '{16'h6789, 1'b1, {7'h02, 7'h78, 7'h00, 7'h18}};
      vec[7] = '{16'h000C, 1'b1, {7'h7F, 7'h7F, 7'h7F, 7'h46}};
      vec[8] = '{16'h0CDE, 1'b1, {7'h7F, 7'h46, 7'h21, 7'h06}};

      // Reset held for three cycles
      for (int c = 0; c < 3; c++) begin
         tick();
         chk("rst_seg", seg_out, 28'hFFFFFFF);
         chk("rst_ack", {27'h0, load_ack}, 28'h0);
         chk("rst_phase", {27'h0, blink_phase}, 28'h0);
      end
      resetN = 1'b1;
      tick();
      chk("post_rst_seg", seg_out, {7'h40, 7'h40, 7'h40, 7'h40});

      // Table-driven single loads through the scoreboard
      for (int t = 0; t < 9; t++) begin
         value    = vec[t].value;
         blank_lz = vec[t].blz;
         load     = 1'b1;
         sbq.push_back('{t, vec[t].exp});
         tick();
         load = 1'b0;
         chk($sformatf("vec%0d_ack", t), {27'h0, load_ack}, 28'h1);
         tick();
         e = sbq.pop_front();
         chk($sformatf("vec%0d_seg", e.idx), seg_out, e.exp);
         chk($sformatf("vec%0d_ack_clr", t), {27'h0, load_ack}, 28'h0);
      end

      // Back-to-back loads
      blank_lz = 1'b0;
      load  = 1'b1;
      value = 16'h0000;
      tick();
      chk("b2b_ack0", {27'h0, load_ack}, 28'h1);
      value = 16'hFFFF;
      tick();
      load = 1'b0;
      chk("b2b_ack1", {27'h0, load_ack}, 28'h1);
      tick();
      chk("b2b_ack_clr", {27'h0, load_ack}, 28'h0);
      chk("b2b_seg", seg_out, {7'h0E, 7'h0E, 7'h0E, 7'h0E});

      // Blink on digit 0
      blink_mask = 4'b0001;
      value = 16'h1234;
      load  = 1'b1;
      tick();
      load = 1'b0;
      tick();
      prev_phase = blink_phase;
      run = 0;
      toggles = 0;
      seen = 1'b0;
      for (int c = 0; c < 20; c++) begin
         tick();
         chk("blink_d0", {21'h0, seg_out[6:0]}, {21'h0, (prev_phase ? 7'h7F : 7'h19)});
         chk("blink_hi", {7'h0, seg_out[27:7]}, {7'h0, 7'h79, 7'h24, 7'h30});
         if (blink_phase == prev_phase) begin
            run++;
         end else begin
            if (seen)
               chk("blink_period", 28'(run), 28'd4);
            seen = 1'b1;
            run = 1;
            toggles++;
         end
         prev_phase = blink_phase;
      end
      chk("blink_toggles", 28'(toggles >= 4), 28'h1);

      // Mask removal takes effect on the next update
      found = 1'b0;
      for (int c = 0; c < 10 && !found; c++) begin
         if (blink_phase) found = 1'b1;
         else tick();
      end
      blink_mask = 4'b0000;
      tick();
      chk("unmask_d0", {21'h0, seg_out[6:0]}, 28'h19);

      // Reset during ack and while blinking
      blink_mask = 4'b0001;
      found = 1'b0;
      for (int c = 0; c < 10 && !found; c++) begin
         tick();
         if (blink_phase) found = 1'b1;
      end
      chk("wait_phase1", {27'h0, found}, 28'h1);
      load  = 1'b1;
      value = 16'h5555;
      tick();
      load = 1'b0;
      chk("pre_rst_ack", {27'h0, load_ack}, 28'h1);
      resetN = 1'b0;
      tick();
      chk("midrst_ack", {27'h0, load_ack}, 28'h0);
      chk("midrst_phase", {27'h0, blink_phase}, 28'h0);
      chk("midrst_seg", seg_out, 28'hFFFFFFF);
      blink_mask = 4'b0000;
      load  = 1'b1;
      value = 16'hABCD;
      tick();
      chk("rst_load_ack", {27'h0, load_ack}, 28'h0);
      load   = 1'b0;
      resetN = 1'b1;
      tick();
      chk("rst_load_ignored", seg_out, {7'h40, 7'h40, 7'h40, 7'h40});
      chk("rst_load_noack", {27'h0, load_ack}, 28'h0);

`ifdef HEX_DISPLAY_LAMP_TEST_EN
      value = 16'h1234;
      load  = 1'b1;
      tick();
      load = 1'b0;
      tick();
      chk("lamp_pre_seg", seg_out, {7'h79, 7'h24, 7'h30, 7'h19});
      lamp_test = 1'b1;
      tick();
      lamp_test = 1'b0;
      lit_cnt = 0;
      for (int k = 0; k < 8; k++) begin
         if (seg_out == 28'h0) lit_cnt++;
         if (k == 1) begin
            load  = 1'b1;
            value = 16'hBEEF;
         end else begin
            load = 1'b0;
         end
         tick();
         if (k == 1)
            chk("lamp_load_ack", {27'h0, load_ack}, 28'h1);
      end
      chk("lamp_lit_cycles", 28'(lit_cnt), 28'd5);
      chk("lamp_post_seg", seg_out, {7'h03, 7'h06, 7'h06, 7'h0E});
`else
      lit_cnt = 0;
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
